onchip_memory_dp: RTL and testbench

- Parametrised, true dual-port on-chip memory with two independent Avalon-MM slaves, s1 and s2, on one clock.
- Successor to the single-port, fixed 16-bit x 4096 on-chip RAM.
- Adds configurable width and depth, and an optional output register.
- Adds a readdatavalid pipeline and fully defined collision and read-during-write behaviour.
- Sits on the Nios II system interconnect: s1 is typically instruction/data master traffic, s2 a DMA or second master.

---
 rtl/onchip_memory_dp_pkg.sv | 22 ++
 rtl/onchip_memory_dp_if.sv | 39 +++
 rtl/onchip_memory_dp_rdpipe.sv | 86 ++++++++
 rtl/onchip_memory_dp.sv | 119 +++++++++++
 tb/tb_onchip_memory_dp.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/onchip_memory_dp_pkg.sv
// -----------------------------------------------------------------------------
// onchip_mem_pkg
// Shared constants and helpers for the dual-port on-chip memory slice.
//   RD_LAT_NOREG : read latency (cycles from accepted read to valid beat)
//                  without the output register
//   RD_LAT_REG   : read latency with the output register
//   addr_width_f : word-address width for a given depth (never below 1)
// -----------------------------------------------------------------------------
package onchip_mem_pkg;

   localparam int RD_LAT_NOREG = 32'sd1;
   localparam int RD_LAT_REG   = 32'sd2;

   function automatic int addr_width_f(input int depth);
      if (depth > 32'sd1) begin
         return $clog2(depth);
      end else begin
         return 32'sd1;
      end
   endfunction

endpackage

// File: rtl/onchip_memory_dp_if.sv
// -----------------------------------------------------------------------------
// onchip_memory_dp_if
// One Avalon-MM slave port of the dual-port memory.
//   address       word address
//   chipselect    port select
//   read / write  strobes (write wins when both are set)
//   byteenable    per-byte write mask
//   writedata     write data
//   readdata      read data, meaningful only while readdatavalid=1
//   readdatavalid read data qualifier
// The memory uses the slave modport; the driving master uses master.
// -----------------------------------------------------------------------------
interface onchip_memory_dp_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
) ();

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] address;
   logic                  chipselect;
   logic                  read;
   logic                  write;
   logic [BE_WIDTH-1:0]   byteenable;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;
   logic                  readdatavalid;

   modport slave (
      input  address, chipselect, read, write, byteenable, writedata,
      output readdata, readdatavalid
   );

   modport master (
      output address, chipselect, read, write, byteenable, writedata,
      input  readdata, readdatavalid
   );

endinterface

// File: rtl/onchip_memory_dp_rdpipe.sv
// -----------------------------------------------------------------------------
// onchip_mem_rdpipe
// Per-port read return path: valid shift register of depth 1+OUTREG, the
// optional output data register and the enable-gated valid output.
//   clk, reset     clock and synchronous active-high reset
//   en             global enable (clken & ~reset_req); the pipe freezes when low
//   rd             read accepted this cycle (already qualified by en)
//   ram_rdata      registered RAM read data for the most recent accepted read
//   readdata       data to the slave port
//   readdatavalid  one pulse per accepted read, latency 1+OUTREG
// -----------------------------------------------------------------------------
module onchip_mem_rdpipe
   import onchip_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OUTREG     = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  rd,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [DATA_WIDTH-1:0] readdata,
   output logic                  readdatavalid
);

   localparam int LAT = (OUTREG != 0) ? RD_LAT_REG : RD_LAT_NOREG;

   logic [LAT-1:0] vld_q;
   logic [LAT-1:0] vld_d;
   logic [LAT:0]   vld_shift;

   // Valid pipe advances only while enabled, so a beat stalled by en=0 is
   // presented exactly once when en returns.
   always_comb begin
      vld_shift = {vld_q, rd};
      if (en) begin
         vld_d = vld_shift[LAT-1:0];
      end else begin
         vld_d = vld_q;
      end
   end

   // Valid pipe register; reset drops every read still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   // Masking with reset keeps a beat that lands in the reset cycle from escaping.
   assign readdatavalid = vld_q[LAT-1] & en & ~reset;

   generate
      if (OUTREG != 0) begin : g_outreg
         logic [DATA_WIDTH-1:0] dout_q;
         logic [DATA_WIDTH-1:0] dout_d;

         // Load only when a real beat moves into the output stage, so readdata
         // holds its last value between beats.
         always_comb begin
            if (en && vld_q[0]) begin
               dout_d = ram_rdata;
            end else begin
               dout_d = dout_q;
            end
         end

         // Output data register, cleared by reset.
         always_ff @(posedge clk) begin
            if (reset) begin
               dout_q <= '0;
            end else begin
               dout_q <= dout_d;
            end
         end

         assign readdata = dout_q;
      end else begin : g_noreg
         assign readdata = ram_rdata;
      end
   endgenerate

endmodule

// File: rtl/onchip_memory_dp.sv
// -----------------------------------------------------------------------------
// onchip_memory_dp
// True dual-port byte-lane RAM with two Avalon-MM slaves on one clock.
//   clk        system clock
//   reset      synchronous active-high reset (read pipes only, not contents)
//   clken      global clock enable
//   reset_req  freezes the block while asserted
//   s1, s2     slave ports (see onchip_memory_dp_if)
// Mixed-port read/write to one address returns the old data. On a same-address
// write/write, s1 owns the lanes it enables and s2 fills the remaining ones.
// -----------------------------------------------------------------------------
module onchip_memory_dp
   import onchip_mem_pkg::*;
#(
   parameter int    DATA_WIDTH = 32,
   parameter int    DEPTH      = 4096,
   parameter int    OUTREG     = 0,
   parameter string INIT_FILE  = "onchip_memory_dp.hex"
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clken,
   input  logic                    reset_req,
   onchip_memory_dp_if.slave       s1,
   onchip_memory_dp_if.slave       s2
);

   localparam int ADDR_WIDTH = addr_width_f(DEPTH);
   localparam int BE_WIDTH   = DATA_WIDTH / 8;

   logic [BE_WIDTH-1:0][7:0] mem [DEPTH];

   logic                  en;
   logic                  wr1;
   logic                  wr2;
   logic                  rd1;
   logic                  rd2;
   logic [ADDR_WIDTH-1:0] a1;
   logic [ADDR_WIDTH-1:0] a2;
   logic [BE_WIDTH-1:0]   be2_eff;
   logic [DATA_WIDTH-1:0] rdata1_q;
   logic [DATA_WIDTH-1:0] rdata1_d;
   logic [DATA_WIDTH-1:0] rdata2_q;
   logic [DATA_WIDTH-1:0] rdata2_d;

   // Request decode, write collision masking and RAM read-port data.
   always_comb begin
      en  = clken & ~reset_req;
      a1  = s1.address;
      a2  = s2.address;
      wr1 = s1.chipselect & s1.write & en;
      wr2 = s2.chipselect & s2.write & en;
      // read+write together is treated as a write only
      rd1 = s1.chipselect & s1.read & ~s1.write & en;
      rd2 = s2.chipselect & s2.read & ~s2.write & en;
      // s2 loses every lane s1 is writing at the same address
      if (wr1 && (a1 == a2)) begin
         be2_eff = s2.byteenable & ~s1.byteenable;
      end else begin
         be2_eff = s2.byteenable;
      end
      // Array read happens before the edge's write, giving old data on collision
      if (rd1) begin
         rdata1_d = mem[a1];
      end else begin
         rdata1_d = rdata1_q;
      end
      if (rd2) begin
         rdata2_d = mem[a2];
      end else begin
         rdata2_d = rdata2_q;
      end
   end

   // RAM read registers; left unreset so they map onto block-RAM output latches.
   always_ff @(posedge clk) begin
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
   end

   // Byte-lane writes on both ports; lane masks never overlap on one address.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
         if (wr1 && s1.byteenable[i]) begin
            mem[a1][i] <= s1.writedata[i*8 +: 8];
         end
         if (wr2 && be2_eff[i]) begin
            mem[a2][i] <= s2.writedata[i*8 +: 8];
         end
      end
   end

   onchip_mem_rdpipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUTREG     (OUTREG)
   ) u_rdpipe_s1 (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .rd            (rd1),
      .ram_rdata     (rdata1_q),
      .readdata      (s1.readdata),
      .readdatavalid (s1.readdatavalid)
   );

   onchip_mem_rdpipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUTREG     (OUTREG)
   ) u_rdpipe_s2 (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .rd            (rd2),
      .ram_rdata     (rdata2_q),
      .readdata      (s2.readdata),
      .readdatavalid (s2.readdatavalid)
   );

endmodule

// File: tb/tb_onchip_memory_dp.sv
// -----------------------------------------------------------------------------
// tb_onchip_memory_dp
// Drives two instances (OUTREG=0 and OUTREG=1) with identical directed traffic.
// Expected read data is queued per port when a read is issued; a negedge
// monitor pops and compares whenever readdatavalid is high.
// Queue index: 0 dut0.s1, 1 dut0.s2, 2 dut1.s1, 3 dut1.s2.
// -----------------------------------------------------------------------------
module tb_onchip_memory_dp;

   localparam int DW    = 32;
   localparam int DEPTH = 256;
   localparam int AW    = 8;

   logic clk;
   logic reset;
   logic clken;
   logic reset_req;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] exp_q [4][$];

   onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0_s1 ();
   onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0_s2 ();
   onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1_s1 ();
   onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1_s2 ();

   onchip_memory_dp #(
      .DATA_WIDTH (DW), .DEPTH (DEPTH), .OUTREG (0), .INIT_FILE ("")
   ) dut0 (
      .clk (clk), .reset (reset), .clken (clken), .reset_req (reset_req),
      .s1 (if0_s1), .s2 (if0_s2)
   );

   onchip_memory_dp #(
      .DATA_WIDTH (DW), .DEPTH (DEPTH), .OUTREG (1), .INIT_FILE ("")
   ) dut1 (
      .clk (clk), .reset (reset), .clken (clken), .reset_req (reset_req),
      .s1 (if1_s1), .s2 (if1_s2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Drive port p (1 or 2) of both instances identically.
   task automatic drive(input int p, input logic cs, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
      if (p == 1) begin
         if0_s1.chipselect = cs; if0_s1.read = rd; if0_s1.write = wr;
         if0_s1.address = a; if0_s1.byteenable = be; if0_s1.writedata = d;
         if1_s1.chipselect = cs; if1_s1.read = rd; if1_s1.write = wr;
         if1_s1.address = a; if1_s1.byteenable = be; if1_s1.writedata = d;
      end else begin
         if0_s2.chipselect = cs; if0_s2.read = rd; if0_s2.write = wr;
         if0_s2.address = a; if0_s2.byteenable = be; if0_s2.writedata = d;
         if1_s2.chipselect = cs; if1_s2.read = rd; if1_s2.write = wr;
         if1_s2.address = a; if1_s2.byteenable = be; if1_s2.writedata = d;
      end
   endtask

   task automatic wrp(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
      drive(p, 1'b1, 1'b0, 1'b1, a, be, d);
   endtask

   // Issue a read and queue its expected data for both instances.
   task automatic rdp(input int p, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      drive(p, 1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0);
      exp_q[p-1].push_back(exp);
      exp_q[p+1].push_back(exp);
   endtask

   // Advance one cycle, then return both ports to idle.
   task automatic step();
      @(posedge clk);
      #1;
      drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
      drive(2, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
   endtask

   task automatic mon(input int idx, input logic vld, input logic [DW-1:0] data);
      logic [DW-1:0] e;
      if (vld) begin
         if (!clken || reset_req) begin
            checks++;
            errors++;
            $display("FAIL valid_while_frozen q%0d: got valid=1 expected 0", idx);
         end
         if (exp_q[idx].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat q%0d: got %08h expected no beat", idx, data);
         end else begin
            e = exp_q[idx].pop_front();
            chk($sformatf("beat_q%0d", idx), data, e);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, if0_s1.readdatavalid, if0_s1.readdata);
      mon(1, if0_s2.readdatavalid, if0_s2.readdata);
      mon(2, if1_s1.readdatavalid, if1_s1.readdata);
      mon(3, if1_s2.readdatavalid, if1_s2.readdata);
   end

   initial begin
      reset     = 1'b1;
      clken     = 1'b1;
      reset_req = 1'b0;
      drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
      drive(2, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
      repeat (3) step();

      chk("rst_vld_d0s1", {31'd0, if0_s1.readdatavalid}, 32'd0);
      chk("rst_vld_d0s2", {31'd0, if0_s2.readdatavalid}, 32'd0);
      chk("rst_vld_d1s1", {31'd0, if1_s1.readdatavalid}, 32'd0);
      chk("rst_vld_d1s2", {31'd0, if1_s2.readdatavalid}, 32'd0);
      chk("rst_rdata_d1s1", if1_s1.readdata, 32'h0);
      chk("rst_rdata_d1s2", if1_s2.readdata, 32'h0);
      reset = 1'b0;

      // Preload
      wrp(1, 8'h10, 32'hAABBCCDD, 4'hF); wrp(2, 8'h05, 32'hDEADBEEF, 4'hF); step();
      wrp(1, 8'h03, 32'h00000000, 4'hF); step();
      wrp(1, 8'h20, 32'h01010101, 4'hF); wrp(2, 8'h21, 32'h02020202, 4'hF); step();
      wrp(1, 8'h22, 32'h03030303, 4'hF); wrp(2, 8'h23, 32'h04040404, 4'hF); step();
      step();

      // Plain read, latency 1 / 2
      rdp(1, 8'h05, 32'hDEADBEEF); step();
      repeat (3) step();

      // Partial byteenable, then cross-port read
      wrp(1, 8'h10, 32'h11223344, 4'b0101); step();
      rdp(2, 8'h10, 32'hAA22CC44); step();
      repeat (3) step();

      // Write/write collision resolved per byte
      wrp(1, 8'h07, 32'h000000FF, 4'b0001); wrp(2, 8'h07, 32'h12345678, 4'b1111); step();
      rdp(1, 8'h07, 32'h123456FF); step();
      repeat (3) step();

      // Mixed-port collision returns old data
      wrp(2, 8'h03, 32'hCAFEF00D, 4'hF); rdp(1, 8'h03, 32'h00000000); step();
      rdp(1, 8'h03, 32'hCAFEF00D); step();
      repeat (3) step();

      // Burst of 4 with clken dropped for 2 cycles in the middle
      rdp(1, 8'h20, 32'h01010101); step();
      rdp(1, 8'h21, 32'h02020202); step();
      clken = 1'b0; step(); step();
      clken = 1'b1;
      rdp(1, 8'h22, 32'h03030303); step();
      rdp(1, 8'h23, 32'h04040404); step();
      repeat (4) step();

      // reset_req freeze mid-flight still yields exactly one beat
      rdp(1, 8'h21, 32'h02020202); step();
      reset_req = 1'b1; step();
      reset_req = 1'b0;
      repeat (3) step();

      // read+write together is a write only; zero byteenable writes nothing
      drive(1, 1'b1, 1'b1, 1'b1, 8'h30, 4'hF, 32'h00000055); step();
      wrp(2, 8'h30, 32'hFFFFFFFF, 4'b0000); step();
      rdp(1, 8'h30, 32'h00000055); step();
      repeat (3) step();

      // Reset one cycle after an s2 read: the read is dropped
      drive(2, 1'b1, 1'b1, 1'b0, 8'h10, 4'h0, 32'h0); step();
      reset = 1'b1; step();
      reset = 1'b0;
      chk("post_rst_rdata_d1s2", if1_s2.readdata, 32'h0);
      repeat (4) step();
      chk("hold_rst_rdata_d1s2", if1_s2.readdata, 32'h0);
      rdp(2, 8'h10, 32'hAA22CC44); step();
      rdp(1, 8'h07, 32'h123456FF); step();
      repeat (4) step();

      // Drain with a bounded wait, then every queue must be empty
      for (int i = 0; i < 20; i++) begin
         if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0) begin
            step();
         end
      end
      for (int q = 0; q < 4; q++) begin
         chk($sformatf("drain_q%0d", q), exp_q[q].size(), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
